box_norm_round: RTL and testbench

Normalisation stage that sits directly after the box-filter coefficient multiplier. The multiplier produces a 28-bit signed product: an 8-bit unsigned box sum times a 20-bit signed Q4.16 reciprocal of the box area. This block rounds that product, shifts out the fractional bits, clamps the result to an 8-bit unsigned pixel, and forwards it over a valid/ready stream with frame and line markers. It also counts saturation events and flags malformed lines for the plate-detection front end.

---
 rtl/box_norm_round.sv | 164 ++++++++++++++++
 tb/tb_box_norm_round.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/box_norm_round.sv
// Rounds a signed multiplier product, drops the fractional bits and clamps it to an
// unsigned pixel on a two-stage valid/ready pipeline; also counts clamps and checks line lengths.
module box_norm_round #(
   parameter int DIN_W     = 28,
   parameter int FRAC_BITS = 16,
   parameter int DOUT_W    = 8,
   parameter int IMG_W     = 640
) (
   input  logic              ap_clk,
   input  logic              ap_rst_n,
   input  logic [DIN_W-1:0]  s_tdata,
   input  logic              s_tvalid,
   output logic              s_tready,
   input  logic              s_tuser,
   input  logic              s_tlast,
   output logic [DOUT_W-1:0] m_tdata,
   output logic              m_tvalid,
   input  logic              m_tready,
   output logic              m_tuser,
   output logic              m_tlast,
   output logic [15:0]       sat_cnt,
   output logic              line_err,
   input  logic              clr
);

   localparam logic [DIN_W:0] RND      = (DIN_W + 1)'(1) << (FRAC_BITS - 1);
   localparam logic [15:0]    LAST_COL = 16'(IMG_W - 1);

   // stage 1: rounded sum, one bit wider than the product so the offset cannot overflow
   logic                     v1_reg;
   logic signed [DIN_W:0]    sum_reg;
   logic                     user1_reg;
   logic                     last1_reg;
   logic [DIN_W:0]           sum_next;

   // stage 2: clamped pixel as presented downstream
   logic                     v2_reg;
   logic [DOUT_W-1:0]        data2_reg;
   logic                     user2_reg;
   logic                     last2_reg;
   logic                     sat2_reg;
   logic signed [DIN_W:0]    q_w;
   logic [DOUT_W-1:0]        data2_next;
   logic                     sat2_next;

   logic                     load1;
   logic                     load2;
   logic                     in_hs;
   logic                     out_hs;

   logic [15:0]              sat_cnt_reg;
   logic [15:0]              sat_cnt_next;
   logic                     line_err_reg;
   logic                     line_err_next;
   logic [15:0]              col_reg;
   logic [15:0]              col_next;
   logic [15:0]              col_cur;
   logic                     col_bad;

   // S2 frees up when empty or draining; S1 frees up when empty or moving into S2
   assign load2  = !v2_reg || m_tready;
   assign load1  = !v1_reg || load2;
   assign in_hs  = s_tvalid && load1;
   assign out_hs = v2_reg && m_tready;

   assign sum_next = {s_tdata[DIN_W-1], s_tdata} + RND;

   always_comb begin
      q_w        = sum_reg >>> FRAC_BITS;
      data2_next = q_w[DOUT_W-1:0];
      sat2_next  = 1'b0;
      if (q_w[DIN_W]) begin
         data2_next = '0;
         sat2_next  = 1'b1;
      end else if (|q_w[DIN_W-1:DOUT_W]) begin
         data2_next = '1;
         sat2_next  = 1'b1;
      end
   end

   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         v1_reg    <= 1'b0;
         sum_reg   <= '0;
         user1_reg <= 1'b0;
         last1_reg <= 1'b0;
      end else if (load1) begin
         v1_reg <= s_tvalid;
         if (s_tvalid) begin
            sum_reg   <= $signed(sum_next);
            user1_reg <= s_tuser;
            last1_reg <= s_tlast;
         end
      end
   end

   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         v2_reg    <= 1'b0;
         data2_reg <= '0;
         user2_reg <= 1'b0;
         last2_reg <= 1'b0;
         sat2_reg  <= 1'b0;
      end else if (load2) begin
         v2_reg <= v1_reg;
         if (v1_reg) begin
            data2_reg <= data2_next;
            user2_reg <= user1_reg;
            last2_reg <= last1_reg;
            sat2_reg  <= sat2_next;
         end
      end
   end

   // a frame start forces column 0; a line ends on tlast or on reaching the last column
   always_comb begin
      col_cur  = s_tuser ? 16'd0 : col_reg;
      col_next = col_reg;
      col_bad  = 1'b0;
      if (in_hs) begin
         if (s_tlast) begin
            col_bad  = (col_cur != LAST_COL);
            col_next = '0;
         end else if (col_cur == LAST_COL) begin
            col_bad  = 1'b1;
            col_next = '0;
         end else begin
            col_next = col_cur + 16'd1;
         end
      end
   end

   always_comb begin
      sat_cnt_next  = sat_cnt_reg;
      line_err_next = line_err_reg | col_bad;
      if (clr) begin
         sat_cnt_next  = '0;
         line_err_next = 1'b0;
      end else if (out_hs && sat2_reg && (sat_cnt_reg != 16'hFFFF)) begin
         sat_cnt_next = sat_cnt_reg + 16'd1;
      end
   end

   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         sat_cnt_reg  <= '0;
         line_err_reg <= 1'b0;
         col_reg      <= '0;
      end else begin
         sat_cnt_reg  <= sat_cnt_next;
         line_err_reg <= line_err_next;
         col_reg      <= col_next;
      end
   end

   assign s_tready = load1;
   assign m_tvalid = v2_reg;
   assign m_tdata  = data2_reg;
   assign m_tuser  = user2_reg;
   assign m_tlast  = last2_reg;
   assign sat_cnt  = sat_cnt_reg;
   assign line_err = line_err_reg;

endmodule

// File: tb/tb_box_norm_round.sv
// Bench for box_norm_round: directed streams checked every cycle against a
// floor-division model and a FIFO of in-flight samples, plus literal expectations.
module tb_box_norm_round;
   localparam int DIN_W     = 28;
   localparam int FRAC_BITS = 16;
   localparam int DOUT_W    = 8;
   localparam int IMG_W     = 4;

   logic              ap_clk = 1'b0;
   logic              ap_rst_n = 1'b0;
   logic [DIN_W-1:0]  s_tdata = '0;
   logic              s_tvalid = 1'b0;
   logic              s_tready;
   logic              s_tuser = 1'b0;
   logic              s_tlast = 1'b0;
   logic [DOUT_W-1:0] m_tdata;
   logic              m_tvalid;
   logic              m_tready = 1'b1;
   logic              m_tuser;
   logic              m_tlast;
   logic [15:0]       sat_cnt;
   logic              line_err;
   logic              clr = 1'b0;

   box_norm_round #(
      .DIN_W(DIN_W), .FRAC_BITS(FRAC_BITS), .DOUT_W(DOUT_W), .IMG_W(IMG_W)
   ) dut (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
      .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
      .s_tuser(s_tuser), .s_tlast(s_tlast),
      .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
      .m_tuser(m_tuser), .m_tlast(m_tlast),
      .sat_cnt(sat_cnt), .line_err(line_err), .clr(clr)
   );

   always #5 ap_clk = ~ap_clk;

   typedef struct {
      logic [7:0] data;
      logic       user;
      logic       last;
      logic       sat;
      int         e;
   } item_t;

   item_t      mq[$];
   logic [7:0] log_d[$];
   logic [1:0] log_f[$];
   int         checks = 0;
   int         failures = 0;
   int         edge_n = 0;
   bit         armed = 1'b0;
   logic [15:0] sat_m = '0;
   logic       err_m = 1'b0;
   int         col_m = 0;
   int         rmode = 1;

   int exp_round[4] = '{100, 100, 101, 101};
   int exp_clamp[4] = '{0, 255, 255, 255};
   int exp_flags[12] = '{2, 0, 0, 1, 2, 0, 1, 2, 0, 0, 0, 1};

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   // round half up = floor((x + 2^15) / 2^16), then clamp to 0..255
   function automatic item_t model(input logic [27:0] x, input logic u, input logic l, input int e);
      item_t  r;
      longint v;
      longint q;
      v = longint'($signed(x)) + 64'sd32768;
      if (v >= 0) q = v / 65536;
      else q = -((-v + 65535) / 65536);
      r.user = u;
      r.last = l;
      r.e    = e;
      if (q < 0) begin
         r.data = 8'd0;
         r.sat  = 1'b1;
      end else if (q > 255) begin
         r.data = 8'd255;
         r.sat  = 1'b1;
      end else begin
         r.data = q[7:0];
         r.sat  = 1'b0;
      end
      return r;
   endfunction

   always @(posedge ap_clk) edge_n++;

   always @(posedge ap_clk) begin
      #1;
      case (rmode)
         0: m_tready = 1'b0;
         2: m_tready = 1'($urandom_range(0, 1));
         default: m_tready = 1'b1;
      endcase
   end

   // per-cycle compare against the model, then predict what the next edge does
   bit    ev, er, in_hs, out_hs, bad;
   item_t it;
   int    c;
   always @(negedge ap_clk) begin
      if (armed) begin
         ev = (mq.size() > 0) && (edge_n >= mq[0].e + 1);
         er = !((mq.size() == 2) && !m_tready);
         check("m_tvalid", m_tvalid, ev);
         check("s_tready", s_tready, er);
         if (ev) begin
            check("m_tdata", m_tdata, mq[0].data);
            check("m_tuser", m_tuser, mq[0].user);
            check("m_tlast", m_tlast, mq[0].last);
         end
         check("sat_cnt", sat_cnt, sat_m);
         check("line_err", line_err, err_m);
      end
      if (!ap_rst_n) begin
         mq.delete();
         sat_m = '0;
         err_m = 1'b0;
         col_m = 0;
         armed = 1'b1;
      end else if (armed) begin
         in_hs  = s_tvalid && er;
         out_hs = ev && m_tready;
         if (out_hs) begin
            it = mq.pop_front();
            log_d.push_back(m_tdata);
            log_f.push_back({m_tuser, m_tlast});
         end
         if (clr) sat_m = '0;
         else if (out_hs && it.sat && sat_m != 16'hFFFF) sat_m = sat_m + 16'd1;
         if (in_hs) begin
            mq.push_back(model(s_tdata, s_tuser, s_tlast, edge_n + 1));
            c   = s_tuser ? 0 : col_m;
            bad = 1'b0;
            if (s_tlast) begin
               bad   = (c != IMG_W - 1);
               col_m = 0;
            end else if (c == IMG_W - 1) begin
               bad   = 1'b1;
               col_m = 0;
            end else begin
               col_m = c + 1;
            end
            if (bad) err_m = 1'b1;
         end
         if (clr) err_m = 1'b0;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge ap_clk);
         #1;
      end
   endtask

   task automatic send(input logic [27:0] d, input logic u, input logic l);
      int n = 0;
      s_tdata  = d;
      s_tuser  = u;
      s_tlast  = l;
      s_tvalid = 1'b1;
      @(negedge ap_clk);
      while (!s_tready && n < 200) begin
         @(negedge ap_clk);
         n++;
      end
      check("send_accept", s_tready, 1);
      @(posedge ap_clk);
      #1;
      s_tvalid = 1'b0;
      s_tuser  = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (mq.size() != 0 && n < 1000) begin
         tick(1);
         n++;
      end
      check("drain_done", mq.size(), 0);
      tick(1);
   endtask

   task automatic clr_pulse();
      clr = 1'b1;
      tick(1);
      clr = 1'b0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      tick(2);
      ap_rst_n = 1'b1;
      check("rst_m_tvalid", m_tvalid, 0);
      check("rst_s_tready", s_tready, 1);
      check("rst_m_tdata", m_tdata, 0);
      check("rst_sat_cnt", sat_cnt, 0);
      check("rst_line_err", line_err, 0);

      // rounding
      log_d.delete();
      send(28'h0640000, 1, 0);
      send(28'h0647FFF, 0, 0);
      send(28'h0648000, 0, 0);
      send(28'h064FFFF, 0, 1);
      drain();
      check("round_count", log_d.size(), 4);
      for (int i = 0; i < 4; i++)
         if (i < log_d.size()) check("round_data", log_d[i], exp_round[i]);
      check("round_sat_cnt", sat_cnt, 0);

      // clamping
      log_d.delete();
      send(28'hFFF0000, 1, 0);
      send(28'h12C0000, 0, 0);
      send(28'h0FF7FFF, 0, 0);
      send(28'h0FF8000, 0, 1);
      drain();
      check("clamp_count", log_d.size(), 4);
      for (int i = 0; i < 4; i++)
         if (i < log_d.size()) check("clamp_data", log_d[i], exp_clamp[i]);
      check("clamp_sat_cnt", sat_cnt, 3);

      // backpressure: sample k carries (20k+5) + 0x9000/0x10000, rounding up to 20k+6
      log_d.delete();
      rmode = 2;
      for (int i = 0; i < 10; i++)
         send(28'((20 * i + 5) << 16) | 28'h0009000, i == 0, (i == 3) || (i == 7));
      rmode = 1;
      tick(1);
      drain();
      check("bp_count", log_d.size(), 10);
      for (int i = 0; i < 10; i++)
         if (i < log_d.size()) check("bp_data", log_d[i], 20 * i + 6);

      // line checking: lines of 4, 3 and 5 samples; sample k carries value k
      clr_pulse();
      log_d.delete();
      log_f.delete();
      k = 1;
      send(28'(k++) << 16, 1, 0);
      send(28'(k++) << 16, 0, 0);
      send(28'(k++) << 16, 0, 0);
      send(28'(k++) << 16, 0, 1);
      check("line4_err", line_err, 0);
      send(28'(k++) << 16, 1, 0);
      send(28'(k++) << 16, 0, 0);
      check("line3_err_before", line_err, 0);
      send(28'(k++) << 16, 0, 1);
      check("line3_err_after", line_err, 1);
      clr_pulse();
      check("clr_line_err", line_err, 0);
      send(28'(k++) << 16, 1, 0);
      send(28'(k++) << 16, 0, 0);
      send(28'(k++) << 16, 0, 0);
      check("line5_err_col2", line_err, 0);
      send(28'(k++) << 16, 0, 0);
      check("line5_err_col3", line_err, 1);
      send(28'(k++) << 16, 0, 1);
      drain();
      check("line_count", log_d.size(), 12);
      for (int i = 0; i < 12; i++)
         if (i < log_d.size()) begin
            check("line_data", log_d[i], i + 1);
            check("line_flags", log_f[i], exp_flags[i]);
         end

      // clr coinciding with a saturating output handshake
      send(28'hFFF0000, 0, 0);
      tick(1);
      clr = 1'b1;
      tick(1);
      clr = 1'b0;
      check("clr_vs_sat", sat_cnt, 0);

      // saturation counter stops at 0xFFFF
      log_d.delete();
      for (int i = 0; i < 65540; i++) send(28'h12C0000, 0, 0);
      drain();
      check("sat_hold", sat_cnt, 16'hFFFF);
      check("sat_outputs", log_d.size(), 65540);

      // reset with two samples in flight
      rmode = 0;
      tick(2);
      log_d.delete();
      send(28'h12C0000, 0, 0);
      send(28'hFFF0000, 0, 0);
      check("full_s_tready", s_tready, 0);
      ap_rst_n = 1'b0;
      tick(1);
      ap_rst_n = 1'b1;
      check("mrst_m_tvalid", m_tvalid, 0);
      check("mrst_m_tdata", m_tdata, 0);
      check("mrst_m_tuser", m_tuser, 0);
      check("mrst_m_tlast", m_tlast, 0);
      check("mrst_sat_cnt", sat_cnt, 0);
      check("mrst_line_err", line_err, 0);
      check("mrst_s_tready", s_tready, 1);
      rmode = 1;
      tick(4);
      check("mrst_no_output", log_d.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
